cond_branch_ex_mem_unit: RTL and testbench

Branch-resolution and EX/MEM staging block of the pipelined ARM-subset CPU. Combinationally evaluates a 4-bit ARM condition field against the current status flags, produces the branch-taken select (PC source = target address, IF/ID flush) for a branch in ID, and holds the EX→MEM pipeline register carrying ALU result, store data, destination register and memory/writeback control into the MEM stage.

---
 rtl/cond_branch_ex_mem_unit_if.sv | 54 +++++
 rtl/cond_branch_ex_mem_unit.sv | 87 ++++++++
 tb/tb_cond_branch_ex_mem_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cond_branch_ex_mem_unit_if.sv
// rtl/cond_branch_ex_mem_unit_if.sv - branch-condition and EX/MEM staging signal bundle
// Optional flush input present only when EX_MEM_FLUSH_EN is defined.
interface cond_branch_ex_mem_unit_if;
  logic [3:0]  cc_in;
  logic [3:0]  instr_condition;
  logic        b_instr;
  logic        asserted;
  logic        choose_ta_r_nop;

  logic [31:0] mux_out_3_C;
  logic [31:0] A_O;
  logic [3:0]  EX_Bit15_12;
  logic [3:0]  cc_main_alu_out;
  logic        EX_load_instr;
  logic        EX_RF_Enable;
  logic        EX_mem_read_write;
  logic        EX_mem_size;
`ifdef EX_MEM_FLUSH_EN
  logic        flush;
`endif

  logic [31:0] MEM_A_O;
  logic [31:0] MEM_MUX3;
  logic [3:0]  MEM_Bit15_12;
  logic [3:0]  MEM_cc;
  logic        MEM_load_instr;
  logic        MEM_RF_Enable;
  logic        MEM_mem_read_write;
  logic        MEM_mem_size;

  modport master (
    output cc_in, instr_condition, b_instr,
    output mux_out_3_C, A_O, EX_Bit15_12, cc_main_alu_out,
    output EX_load_instr, EX_RF_Enable, EX_mem_read_write, EX_mem_size,
`ifdef EX_MEM_FLUSH_EN
    output flush,
`endif
    input  asserted, choose_ta_r_nop,
    input  MEM_A_O, MEM_MUX3, MEM_Bit15_12, MEM_cc,
    input  MEM_load_instr, MEM_RF_Enable, MEM_mem_read_write, MEM_mem_size
  );

  modport slave (
    input  cc_in, instr_condition, b_instr,
    input  mux_out_3_C, A_O, EX_Bit15_12, cc_main_alu_out,
    input  EX_load_instr, EX_RF_Enable, EX_mem_read_write, EX_mem_size,
`ifdef EX_MEM_FLUSH_EN
    input  flush,
`endif
    output asserted, choose_ta_r_nop,
    output MEM_A_O, MEM_MUX3, MEM_Bit15_12, MEM_cc,
    output MEM_load_instr, MEM_RF_Enable, MEM_mem_read_write, MEM_mem_size
  );
endinterface

// File: rtl/cond_branch_ex_mem_unit.sv
// rtl/cond_branch_ex_mem_unit.sv - ARM condition evaluation, branch select and EX/MEM pipeline register
// Define EX_MEM_FLUSH_EN to add a flush input that bubbles the MEM-stage control bits.
module cond_branch_ex_mem_unit (
  input logic                      clk,
  input logic                      Reset,
  cond_branch_ex_mem_unit_if.slave bus
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_true;

  assign flag_n = bus.cc_in[3];
  assign flag_z = bus.cc_in[2];
  assign flag_c = bus.cc_in[1];
  assign flag_v = bus.cc_in[0];

  always_comb begin
    cond_true = 1'b0;
    unique case (bus.instr_condition)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = !flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = !flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = !flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = !flag_v;
      4'b1000: cond_true = flag_c && !flag_z;
      4'b1001: cond_true = !flag_c || flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = !flag_z && (flag_n == flag_v);
      4'b1101: cond_true = flag_z || (flag_n != flag_v);
      4'b1110: cond_true = 1'b1;
      4'b1111: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Only a branch redirects the PC; a failed-condition branch falls through.
  assign bus.asserted        = cond_true;
  assign bus.choose_ta_r_nop = cond_true & bus.b_instr;

  logic [31:0] mem_a_o_q, mem_mux3_q;
  logic [3:0]  mem_bit15_12_q, mem_cc_q;
  logic        mem_load_q, mem_rf_en_q, mem_rw_q, mem_size_q;
  logic        bubble;

`ifdef EX_MEM_FLUSH_EN
  assign bubble = bus.flush;
`else
  assign bubble = 1'b0;
`endif

  // No stall path: the register captures every cycle; data still loads during a bubble.
  always_ff @(posedge clk) begin
    if (Reset) begin
      mem_a_o_q      <= 32'd0;
      mem_mux3_q     <= 32'd0;
      mem_bit15_12_q <= 4'd0;
      mem_cc_q       <= 4'd0;
      mem_load_q     <= 1'b0;
      mem_rf_en_q    <= 1'b0;
      mem_rw_q       <= 1'b0;
      mem_size_q     <= 1'b0;
    end else begin
      mem_a_o_q      <= bus.A_O;
      mem_mux3_q     <= bus.mux_out_3_C;
      mem_bit15_12_q <= bus.EX_Bit15_12;
      mem_cc_q       <= bus.cc_main_alu_out;
      mem_load_q     <= bus.EX_load_instr & ~bubble;
      mem_rf_en_q    <= bus.EX_RF_Enable & ~bubble;
      mem_rw_q       <= bus.EX_mem_read_write & ~bubble;
      mem_size_q     <= bus.EX_mem_size;
    end
  end

  assign bus.MEM_A_O            = mem_a_o_q;
  assign bus.MEM_MUX3           = mem_mux3_q;
  assign bus.MEM_Bit15_12       = mem_bit15_12_q;
  assign bus.MEM_cc             = mem_cc_q;
  assign bus.MEM_load_instr     = mem_load_q;
  assign bus.MEM_RF_Enable      = mem_rf_en_q;
  assign bus.MEM_mem_read_write = mem_rw_q;
  assign bus.MEM_mem_size       = mem_size_q;

endmodule

// File: tb/tb_cond_branch_ex_mem_unit.sv
// tb/tb_cond_branch_ex_mem_unit.sv - directed self-checking bench for cond_branch_ex_mem_unit
module tb_cond_branch_ex_mem_unit;
  logic clk;
  logic Reset;
  int   vectors;
  int   miscompares;

  cond_branch_ex_mem_unit_if bus ();

  cond_branch_ex_mem_unit dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // asserted truth table per condition, bit index = cc_in {N,Z,C,V}
  logic [15:0] cond_mask [16] = '{
    16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
    16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
    16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
    16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a_o, input logic [31:0] mux3,
                           input logic [3:0] rd, input logic [3:0] cc, input logic ld,
                           input logic rf, input logic rw, input logic sz);
    check({tag, "_A_O"},   bus.MEM_A_O, a_o);
    check({tag, "_MUX3"},  bus.MEM_MUX3, mux3);
    check({tag, "_rd"},    {28'd0, bus.MEM_Bit15_12}, {28'd0, rd});
    check({tag, "_cc"},    {28'd0, bus.MEM_cc}, {28'd0, cc});
    check({tag, "_ctrl"},
          {28'd0, bus.MEM_load_instr, bus.MEM_RF_Enable, bus.MEM_mem_read_write, bus.MEM_mem_size},
          {28'd0, ld, rf, rw, sz});
  endtask

  task automatic drive_ex(input logic [31:0] a_o, input logic [31:0] mux3, input logic [3:0] rd,
                          input logic [3:0] cc, input logic ld, input logic rf,
                          input logic rw, input logic sz);
    bus.A_O               = a_o;
    bus.mux_out_3_C       = mux3;
    bus.EX_Bit15_12       = rd;
    bus.cc_main_alu_out   = cc;
    bus.EX_load_instr     = ld;
    bus.EX_RF_Enable      = rf;
    bus.EX_mem_read_write = rw;
    bus.EX_mem_size       = sz;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset = 1'b1;
    bus.cc_in = 4'b0000;
    bus.instr_condition = 4'b1110;
    bus.b_instr = 1'b1;
`ifdef EX_MEM_FLUSH_EN
    bus.flush = 1'b0;
`endif
    drive_ex(32'hDEADBEEF, 32'hFFFFFFFF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);

    // reset with nonzero inputs; branch outputs unaffected by Reset
    @(posedge clk); #1;
    check_mem("reset", 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_choose", {31'd0, bus.choose_ta_r_nop}, 32'd1);

    // first capture; outputs unchanged before the edge
    Reset = 1'b0;
    drive_ex(32'd12, 32'd7, 4'd5, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    check_mem("pre_edge", 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_mem("cap1", 32'd12, 32'd7, 4'd5, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);

    // complementary control pattern; then hold until next edge
    drive_ex(32'hA5A5_0001, 32'h1234_5678, 4'hA, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_mem("cap2", 32'hA5A5_0001, 32'h1234_5678, 4'hA, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_ex(32'd99, 32'd98, 4'd3, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    check_mem("hold", 32'hA5A5_0001, 32'h1234_5678, 4'hA, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b1);

    // mid-stream reset drops the EX instruction on that edge
    Reset = 1'b1;
    @(posedge clk); #1;
    check_mem("mid_reset", 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    @(posedge clk); #1;
    check_mem("post_reset", 32'd99, 32'd98, 4'd3, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef EX_MEM_FLUSH_EN
    bus.flush = 1'b1;
    drive_ex(32'd40, 32'd41, 4'd6, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_mem("flush", 32'd40, 32'd41, 4'd6, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.flush = 1'b0;
    @(posedge clk); #1;
    check_mem("unflush", 32'd40, 32'd41, 4'd6, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1);
`endif

    // full condition sweep with b_instr=1
    bus.b_instr = 1'b1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        bus.instr_condition = c[3:0];
        bus.cc_in = f[3:0];
        #1;
        check($sformatf("asserted_c%0d_f%0d", c, f), {31'd0, bus.asserted}, {31'd0, cond_mask[c][f]});
        check($sformatf("choose_c%0d_f%0d", c, f), {31'd0, bus.choose_ta_r_nop}, {31'd0, cond_mask[c][f]});
      end
    end

    // directed branch cases
    bus.instr_condition = 4'b0000; bus.cc_in = 4'b0100; #1;
    check("beq_taken", {31'd0, bus.choose_ta_r_nop}, 32'd1);
    bus.cc_in = 4'b0000; #1;
    check("beq_not_taken", {31'd0, bus.choose_ta_r_nop}, 32'd0);
    bus.b_instr = 1'b0; bus.instr_condition = 4'b1110; #1;
    check("al_nonbranch_asserted", {31'd0, bus.asserted}, 32'd1);
    check("al_nonbranch_choose", {31'd0, bus.choose_ta_r_nop}, 32'd0);
    bus.instr_condition = 4'b1100; bus.cc_in = 4'b1001; #1;
    check("gt_nonbranch_asserted", {31'd0, bus.asserted}, 32'd1);
    check("gt_nonbranch_choose", {31'd0, bus.choose_ta_r_nop}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
